// File: rtl/aximm_seq_pkg.sv
// Shared types and constants for the AXI link test sequencer.
// States, AXI encodings, beat pattern prefix and the beat-size helper.
package aximm_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_LINK = 3'd1;
  localparam state_t S_AW   = 3'd2;
  localparam state_t S_W    = 3'd3;
  localparam state_t S_B    = 3'd4;
  localparam state_t S_AR   = 3'd5;
  localparam state_t S_R    = 3'd6;
  localparam state_t S_DONE = 3'd7;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [15:0] PAT_PREFIX = 16'hA5C3;

  function automatic logic [2:0] axi_size(input int unsigned dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/aximm_seq_patgen.sv
// Beat pattern generator: {prefix, beat index} replicated across the bus.
// Shared by the write-data driver and the read-data checker.
module aximm_seq_patgen
  import aximm_seq_pkg::*;
#(
  parameter int DWIDTH = 64
) (
  input  logic [15:0]       beat,
  output logic [DWIDTH-1:0] data
);

  assign data = {(DWIDTH / 32){PAT_PREFIX, beat}};

endmodule

// File: rtl/aximm_link_test_seq.sv
// AXI link test sequencer: one INCR write burst, read-back and compare.
// Optional handshake watchdog built when AXIMM_SEQ_TIMEOUT_EN is defined.
module aximm_link_test_seq
  import aximm_seq_pkg::*;
#(
  parameter int ADDRWIDTH   = 32,
  parameter int DWIDTH      = 64,
  parameter int IDWIDTH     = 4,
  parameter int BURST_LEN   = 8,
  parameter logic [IDWIDTH-1:0] SEQ_ID = IDWIDTH'(4'h5),
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk_wr,
  input  logic                   rst_wr_n,
  input  logic                   i_start,
  input  logic                   i_tx_online,
  input  logic                   i_rx_online,
  input  logic [ADDRWIDTH-1:0]   i_base_addr,
  output logic [IDWIDTH-1:0]     o_awid,
  output logic [ADDRWIDTH-1:0]   o_awaddr,
  output logic [7:0]             o_awlen,
  output logic [2:0]             o_awsize,
  output logic [1:0]             o_awburst,
  output logic                   o_awvalid,
  input  logic                   i_awready,
  output logic [IDWIDTH-1:0]     o_wid,
  output logic [DWIDTH-1:0]      o_wdata,
  output logic [DWIDTH/8-1:0]    o_wstrb,
  output logic                   o_wlast,
  output logic                   o_wvalid,
  input  logic                   i_wready,
  input  logic [IDWIDTH-1:0]     i_bid,
  input  logic [1:0]             i_bresp,
  input  logic                   i_bvalid,
  output logic                   o_bready,
  output logic [IDWIDTH-1:0]     o_arid,
  output logic [ADDRWIDTH-1:0]   o_araddr,
  output logic [7:0]             o_arlen,
  output logic [2:0]             o_arsize,
  output logic [1:0]             o_arburst,
  output logic                   o_arvalid,
  input  logic                   i_arready,
  input  logic [IDWIDTH-1:0]     i_rid,
  input  logic [DWIDTH-1:0]      i_rdata,
  input  logic                   i_rlast,
  input  logic [1:0]             i_rresp,
  input  logic                   i_rvalid,
  output logic                   o_rready,
  output logic                   o_busy,
  output logic [1:0]             o_test_done,
  output logic [15:0]            o_err_cnt,
  output logic                   o_link_lost,
  output logic                   o_timeout
);

  localparam logic [7:0] LAST = 8'(BURST_LEN - 1);
  localparam logic [2:0] SIZE = axi_size(DWIDTH);

  state_t                 state;
  logic [ADDRWIDTH-1:0]   base;
  logic [7:0]             k;
  logic [7:0]             pat_idx;
  logic [DWIDTH-1:0]      pat;
  logic [2:0]             err_add;
  logic [16:0]            err_sum;
  logic [15:0]            err_nxt;
  logic                   in_test;
  logic                   ll_nxt;
  logic                   any_hs;
  logic                   wd_fire;
  logic                   r_end;
  logic                   pass_nxt;
  logic                   aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = o_awvalid & i_awready;
  assign w_hs  = o_wvalid & i_wready;
  assign b_hs  = o_bready & i_bvalid;
  assign ar_hs = o_arvalid & i_arready;
  assign r_hs  = o_rready & i_rvalid;
  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

  assign in_test = (state == S_AW) || (state == S_W) ||
                   (state == S_B) || (state == S_AR) ||
                   (state == S_R);
  assign o_busy = (state != S_IDLE) && (state != S_DONE);
  assign ll_nxt = o_link_lost |
                  (in_test & ~(i_tx_online & i_rx_online));

  // W preloads the next beat; R checks the current one.
  assign pat_idx = (state == S_W) ? k + 8'd1 : k;

  aximm_seq_patgen #(.DWIDTH(DWIDTH)) u_pat (
    .beat ({8'd0, pat_idx}),
    .data (pat)
  );

  always_comb begin
    err_add = '0;
    if (b_hs)
      err_add = 3'(i_bresp != AXI_RESP_OKAY) +
                3'(i_bid != SEQ_ID);
    if (r_hs)
      err_add = 3'(i_rdata != pat) +
                3'(i_rresp != AXI_RESP_OKAY) +
                3'(i_rid != SEQ_ID) +
                3'(i_rlast != (k == LAST));
  end

  assign err_sum  = {1'b0, o_err_cnt} + 17'(err_add);
  assign err_nxt  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  assign r_end    = r_hs & (i_rlast | (k == LAST));
  assign pass_nxt = (err_nxt == 16'd0) & ~ll_nxt;

`ifdef AXIMM_SEQ_TIMEOUT_EN
  logic [31:0] wd_cnt;

  assign wd_fire = in_test & ~any_hs &
                   (wd_cnt == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      if (!o_busy && i_start)
        o_timeout <= 1'b0;
      else if (wd_fire)
        o_timeout <= 1'b1;
      if (!in_test || any_hs || wd_fire)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 32'd1;
    end
  end
`else
  assign wd_fire   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state       <= S_IDLE;
      base        <= '0;
      k           <= '0;
      o_awid      <= '0;
      o_awaddr    <= '0;
      o_awlen     <= '0;
      o_awsize    <= '0;
      o_awburst   <= '0;
      o_awvalid   <= 1'b0;
      o_wid       <= '0;
      o_wdata     <= '0;
      o_wstrb     <= '0;
      o_wlast     <= 1'b0;
      o_wvalid    <= 1'b0;
      o_bready    <= 1'b0;
      o_arid      <= '0;
      o_araddr    <= '0;
      o_arlen     <= '0;
      o_arsize    <= '0;
      o_arburst   <= '0;
      o_arvalid   <= 1'b0;
      o_rready    <= 1'b0;
      o_test_done <= '0;
      o_err_cnt   <= '0;
      o_link_lost <= 1'b0;
    end else begin
      o_err_cnt   <= err_nxt;
      o_link_lost <= ll_nxt;
      if (wd_fire) begin
        o_awvalid   <= 1'b0;
        o_wvalid    <= 1'b0;
        o_bready    <= 1'b0;
        o_arvalid   <= 1'b0;
        o_rready    <= 1'b0;
        o_test_done <= 2'b01;
        state       <= S_DONE;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (i_start) begin
              base        <= i_base_addr;
              k           <= '0;
              o_test_done <= '0;
              o_err_cnt   <= '0;
              o_link_lost <= 1'b0;
              state       <= S_LINK;
            end
          end
          S_LINK: begin
            if (i_tx_online && i_rx_online) begin
              o_awid    <= SEQ_ID;
              o_awaddr  <= base;
              o_awlen   <= LAST;
              o_awsize  <= SIZE;
              o_awburst <= AXI_BURST_INCR;
              o_awvalid <= 1'b1;
              state     <= S_AW;
            end
          end
          S_AW: begin
            if (aw_hs) begin
              o_awvalid <= 1'b0;
              o_wid     <= SEQ_ID;
              o_wdata   <= pat;
              o_wstrb   <= '1;
              o_wlast   <= (LAST == 8'd0);
              o_wvalid  <= 1'b1;
              state     <= S_W;
            end
          end
          S_W: begin
            if (w_hs) begin
              if (o_wlast) begin
                o_wvalid <= 1'b0;
                o_wlast  <= 1'b0;
                o_bready <= 1'b1;
                state    <= S_B;
              end else begin
                k       <= k + 8'd1;
                o_wdata <= pat;
                o_wlast <= (k + 8'd1 == LAST);
              end
            end
          end
          S_B: begin
            if (b_hs) begin
              k         <= '0;
              o_bready  <= 1'b0;
              o_arid    <= SEQ_ID;
              o_araddr  <= base;
              o_arlen   <= LAST;
              o_arsize  <= SIZE;
              o_arburst <= AXI_BURST_INCR;
              o_arvalid <= 1'b1;
              state     <= S_AR;
            end
          end
          S_AR: begin
            if (ar_hs) begin
              o_arvalid <= 1'b0;
              o_rready  <= 1'b1;
              state     <= S_R;
            end
          end
          S_R: begin
            if (r_end) begin
              o_rready    <= 1'b0;
              o_test_done <= {pass_nxt, 1'b1};
              state       <= S_DONE;
            end else if (r_hs) begin
              k <= k + 8'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aximm_link_test_seq.sv
// Directed bench for aximm_link_test_seq with a W-beat scoreboard.
// Watchdog scenario runs only when AXIMM_SEQ_TIMEOUT_EN is defined.
module tb_aximm_link_test_seq;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IW  = 4;
  localparam int LEN = 8;
  localparam int BUDGET = 3000;
  localparam logic [IW-1:0] SID = 4'h5;

  logic clk_wr = 1'b0;
  logic rst_wr_n = 1'b0;
  logic i_start = 1'b0;
  logic i_tx_online = 1'b0;
  logic i_rx_online = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [IW-1:0] o_awid;
  logic [AW-1:0] o_awaddr;
  logic [7:0] o_awlen;
  logic [2:0] o_awsize;
  logic [1:0] o_awburst;
  logic o_awvalid;
  logic i_awready = 1'b0;
  logic [IW-1:0] o_wid;
  logic [DW-1:0] o_wdata;
  logic [DW/8-1:0] o_wstrb;
  logic o_wlast, o_wvalid;
  logic i_wready = 1'b0;
  logic [IW-1:0] i_bid = '0;
  logic [1:0] i_bresp = '0;
  logic i_bvalid = 1'b0;
  logic o_bready;
  logic [IW-1:0] o_arid;
  logic [AW-1:0] o_araddr;
  logic [7:0] o_arlen;
  logic [2:0] o_arsize;
  logic [1:0] o_arburst;
  logic o_arvalid;
  logic i_arready = 1'b0;
  logic [IW-1:0] i_rid = '0;
  logic [DW-1:0] i_rdata = '0;
  logic i_rlast = 1'b0;
  logic [1:0] i_rresp = '0;
  logic i_rvalid = 1'b0;
  logic o_rready, o_busy;
  logic [1:0] o_test_done;
  logic [15:0] o_err_cnt;
  logic o_link_lost, o_timeout;

  aximm_link_test_seq #(
    .ADDRWIDTH(AW), .DWIDTH(DW), .IDWIDTH(IW),
    .BURST_LEN(LEN), .SEQ_ID(SID), .TIMEOUT_CYC(16)
  ) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .i_start(i_start),
    .i_tx_online(i_tx_online), .i_rx_online(i_rx_online),
    .i_base_addr(i_base_addr),
    .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen),
    .o_awsize(o_awsize), .o_awburst(o_awburst),
    .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wid(o_wid), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .o_wlast(o_wlast), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid),
    .o_bready(o_bready),
    .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen),
    .o_arsize(o_arsize), .o_arburst(o_arburst),
    .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rid(i_rid), .i_rdata(i_rdata), .i_rlast(i_rlast),
    .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .o_busy(o_busy), .o_test_done(o_test_done),
    .o_err_cnt(o_err_cnt), .o_link_lost(o_link_lost),
    .o_timeout(o_timeout)
  );

  always #5 clk_wr = ~clk_wr;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } wexp_t;

  wexp_t wq[$];
  logic [DW-1:0] mem [LEN];

  int tests = 0;
  int fails = 0;
  int bp, corrupt_at, early_at, drop_at, rst_at, aw_block;
  logic [1:0] bresp_cfg;
  int wbeats, rbeats, aw_hi, rk, cyc;
  logic b_pend, r_pend, aw_stall, w_stall, did_rst;
  logic [AW-1:0] base_q, aw_prev;
  logic [DW-1:0] w_prev_d;
  logic w_prev_l;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] expw(input int k);
    logic [15:0] kk;
    kk = 16'(k);
    return {16'hA5C3, kk, 16'hA5C3, kk};
  endfunction

  function automatic logic out_any();
    return |{o_awid, o_awaddr, o_awlen, o_awsize, o_awburst,
             o_awvalid, o_wid, o_wdata, o_wstrb, o_wlast,
             o_wvalid, o_bready, o_arid, o_araddr, o_arlen,
             o_arsize, o_arburst, o_arvalid, o_rready, o_busy,
             o_test_done, o_err_cnt, o_link_lost, o_timeout};
  endfunction

  task automatic defaults();
    bp = 0; corrupt_at = -1; early_at = -1; drop_at = -1;
    rst_at = -1; aw_block = 0; bresp_cfg = 2'b00;
    i_tx_online = 1'b1; i_rx_online = 1'b1;
  endtask

  function automatic logic rnd_ready();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_seq(input logic [AW-1:0] base);
    wq.delete();
    wbeats = 0; rbeats = 0; aw_hi = 0; rk = 0; cyc = 0;
    b_pend = 0; r_pend = 0; aw_stall = 0; w_stall = 0;
    did_rst = 0; base_q = base;
    @(negedge clk_wr);
    i_base_addr = base;
    i_start = 1'b1;
    @(negedge clk_wr);
    i_start = 1'b0;
    while (!o_test_done[0] && !did_rst && cyc < BUDGET) begin
      cyc++;
      if (rst_at >= 0 && r_pend && rbeats == rst_at) begin
        rst_wr_n = 1'b0;
        #1;
        chk("rst_outs_zero", 64'(out_any()), 64'd0);
        chk("rst_valids", 64'({o_awvalid, o_wvalid, o_arvalid,
                               o_rready, o_bready}), 64'd0);
        did_rst = 1;
        r_pend = 0;
        i_rvalid = 1'b0;
      end else begin
        if (drop_at >= 0 && wbeats == drop_at) i_rx_online = 1'b0;
        if (aw_stall)
          chk("aw_hold", {31'd0, o_awvalid, o_awaddr},
              {31'd0, 1'b1, aw_prev});
        if (w_stall) begin
          chk("w_hold_data", o_wdata, w_prev_d);
          chk("w_hold_ctl", 64'({o_wvalid, o_wlast}),
              64'({1'b1, w_prev_l}));
        end
        if (o_awvalid) aw_hi++;
        i_awready = aw_block != 0 ? 1'b0 : (bp != 0 ? rnd_ready() : 1'b1);
        i_wready  = bp != 0 ? rnd_ready() : 1'b1;
        i_arready = bp != 0 ? rnd_ready() : 1'b1;
        i_bvalid  = b_pend;
        i_bresp   = bresp_cfg;
        i_bid     = SID;
        i_rvalid  = r_pend && (bp != 0 ? rnd_ready() : 1'b1);
        i_rid     = SID;
        i_rresp   = 2'b00;
        i_rdata   = r_pend ? (mem[rk] ^ ((rk == corrupt_at) ? 64'd1 : 64'd0))
                           : '0;
        i_rlast   = r_pend && (rk == LEN - 1 || rk == early_at);
        aw_stall = o_awvalid && !i_awready && aw_block == 0;
        aw_prev  = o_awaddr;
        w_stall  = o_wvalid && !i_wready;
        w_prev_d = o_wdata;
        w_prev_l = o_wlast;
        if (o_awvalid && i_awready) begin
          chk("awaddr", 64'(o_awaddr), 64'(base_q));
          chk("awlen", 64'(o_awlen), 64'd7);
          chk("awsize", 64'(o_awsize), 64'd3);
          chk("awburst_id", 64'({o_awburst, o_awid}), 64'({2'b01, 4'h5}));
          for (int k = 0; k < LEN; k++)
            wq.push_back('{d: expw(k), l: (k == LEN - 1)});
        end
        if (o_wvalid && i_wready) begin
          chk("w_in_burst", 64'(wbeats < LEN && wq.size() > 0), 64'd1);
          if (wq.size() > 0) begin
            wexp_t e;
            e = wq.pop_front();
            chk("wdata", o_wdata, e.d);
            chk("wlast", 64'(o_wlast), 64'(e.l));
            chk("wstrb_wid", 64'({o_wstrb, o_wid}), 64'({8'hFF, 4'h5}));
          end
          if (wbeats == 3)
            chk("wdata_beat3", o_wdata, 64'hA5C30003_A5C30003);
          if (wbeats < LEN) mem[wbeats] = o_wdata;
          wbeats++;
          if (o_wlast) b_pend = 1;
        end
        if (o_bready && i_bvalid) b_pend = 0;
        if (o_arvalid && i_arready) begin
          chk("araddr", 64'(o_araddr), 64'(base_q));
          chk("ar_fields", 64'({o_arlen, o_arsize, o_arburst, o_arid}),
              64'({8'd7, 3'd3, 2'b01, 4'h5}));
          r_pend = 1;
          rk = 0;
        end
        if (o_rready && i_rvalid) begin
          rbeats++;
          if (i_rlast) r_pend = 0;
          rk++;
        end
        @(negedge clk_wr);
      end
    end
    chk("in_budget", 64'(cyc < BUDGET), 64'd1);
  endtask

  initial begin
    defaults();
    i_tx_online = 1'b0;
    i_rx_online = 1'b0;
    repeat (3) @(negedge clk_wr);
    chk("reset_outs", 64'(out_any()), 64'd0);
    rst_wr_n = 1'b1;
    @(negedge clk_wr);
    chk("post_reset_outs", 64'(out_any()), 64'd0);

    // clean burst
    defaults();
    run_seq(32'h100);
    chk("t1_done", 64'(o_test_done), 64'd3);
    chk("t1_err", 64'(o_err_cnt), 64'd0);
    chk("t1_wbeats", 64'(wbeats), 64'd8);
    chk("t1_rbeats", 64'(rbeats), 64'd8);
    chk("t1_busy", 64'(o_busy), 64'd0);
    chk("t1_flags", 64'({o_link_lost, o_timeout}), 64'd0);

    // corrupted read beat 5
    defaults();
    corrupt_at = 5;
    run_seq(32'h2000);
    chk("t2_err", 64'(o_err_cnt), 64'd1);
    chk("t2_done", 64'(o_test_done), 64'd1);

    // random backpressure
    defaults();
    bp = 1;
    run_seq(32'h3400);
    chk("t3_wbeats", 64'(wbeats), 64'd8);
    chk("t3_done", 64'(o_test_done), 64'd3);
    chk("t3_err", 64'(o_err_cnt), 64'd0);

    // SLVERR plus early rlast on beat 2
    defaults();
    bresp_cfg = 2'b10;
    early_at = 2;
    run_seq(32'h480);
    chk("t4_err", 64'(o_err_cnt), 64'd2);
    chk("t4_rbeats", 64'(rbeats), 64'd3);
    chk("t4_done", 64'(o_test_done), 64'd1);

    // link drop during W
    defaults();
    drop_at = 3;
    run_seq(32'h500);
    chk("t5_link_lost", 64'(o_link_lost), 64'd1);
    chk("t5_wbeats", 64'(wbeats), 64'd8);
    chk("t5_err", 64'(o_err_cnt), 64'd0);
    chk("t5_done", 64'(o_test_done), 64'd1);

    // async reset mid-read
    defaults();
    rst_at = 2;
    run_seq(32'h600);
    chk("t6_rst_hit", 64'(did_rst), 64'd1);
    @(negedge clk_wr);
    chk("t6_held_zero", 64'(out_any()), 64'd0);
    rst_wr_n = 1'b1;
    @(negedge clk_wr);

`ifdef AXIMM_SEQ_TIMEOUT_EN
    defaults();
    aw_block = 1;
    run_seq(32'h700);
    chk("t7_timeout", 64'(o_timeout), 64'd1);
    chk("t7_aw_cycles", 64'(aw_hi), 64'd16);
    chk("t7_awvalid", 64'(o_awvalid), 64'd0);
    chk("t7_done", 64'(o_test_done), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
